// File: rtl/div_pkg.sv
// Shared encodings and default sizing for the programmable clock divider.
// The FSM state encoding is fixed so debug tools can decode dbgState directly.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEF_CNT_W   = 26;
  localparam int DEF_TICKS_W = 16;
  localparam int DEF_DIV     = 50_000_000;

endpackage

// File: rtl/div_ctrl_if.sv
// Control, config and tick bus between the register logic and div_ctrl.
// Config handshake: a word moves on any rising edge where iCfgValid && oCfgReady;
// the master holds iCfgValid and the data stable until that edge, and ready never
// depends on valid.
interface div_ctrl_if
  import div_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int TICKS_W = DEF_TICKS_W
);
  logic               iCfgValid;
  logic               oCfgReady;
  logic [CNT_W-1:0]   iCfgDiv;
  logic [TICKS_W-1:0] iCfgCount;
  logic               iStart;
  logic               iStop;
  logic               oTick;
  logic               oBusy;
  logic               oDone;
  logic [TICKS_W-1:0] oTickCnt;
  state_e             dbgState;

  modport slave (
    input  iCfgValid, iCfgDiv, iCfgCount, iStart, iStop,
    output oCfgReady, oTick, oBusy, oDone, oTickCnt, dbgState
  );

  modport master (
    output iCfgValid, iCfgDiv, iCfgCount, iStart, iStop,
    input  oCfgReady, oTick, oBusy, oDone, oTickCnt, dbgState
  );
endinterface

// File: rtl/div_core.sv
// Programmable counter/compare: counts 0..iDiv while enabled and flags the
// terminal count as a tick. iClr discards any partial period.
module div_core #(
  parameter int CNT_W = 26
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iEn,
  input  logic             iClr,
  input  logic [CNT_W-1:0] iDiv,
  output logic             oTick
);

  logic [CNT_W-1:0] cnt;

  assign oTick = iEn && (cnt == iDiv);

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      cnt <= '0;
    end else if (iClr) begin
      cnt <= '0;
    end else if (iEn) begin
      cnt <= oTick ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/div_ctrl.sv
// Run-control for the clock divider: config latch, IDLE/RUN/DONE FSM,
// one-shot tick budget and the ticks-since-start counter.
module div_ctrl
  import div_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int TICKS_W     = DEF_TICKS_W,
  parameter int DEFAULT_DIV = DEF_DIV
) (
  input  logic       iClk,
  input  logic       iRst,
  div_ctrl_if.slave  bus
);

  state_e             state;
  state_e             nextState;
  logic [CNT_W-1:0]   divReg;
  logic [TICKS_W-1:0] budget;
  logic [TICKS_W-1:0] tickCnt;
  logic               coreTick;
  logic               coreEn;
  logic               coreClr;
  logic               lastTick;
  logic               cfgReady;
  logic               startRun;

  assign coreEn   = (state == RUN);
  assign cfgReady = (state != RUN);
  // Budget 0 means continuous; the compare wraps with the counter width.
  assign lastTick = coreTick && (budget != '0) && ((tickCnt + TICKS_W'(1)) == budget);
  assign startRun = (state != RUN) && (nextState == RUN);

  always_comb begin
    nextState = state;
    case (state)
      IDLE, DONE: begin
        if (bus.iStop)       nextState = IDLE;
        else if (bus.iStart) nextState = RUN;
      end
      RUN: begin
        if (bus.iStop)       nextState = IDLE;
        else if (lastTick)   nextState = DONE;
      end
      default:               nextState = IDLE;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) state <= IDLE;
    else      state <= nextState;
  end

  // Leaving RUN or sitting outside it keeps the divider at the start of a period.
  assign coreClr = (state != RUN) || (nextState != RUN);

  div_core #(.CNT_W(CNT_W)) u_core (
    .iClk (iClk),
    .iRst (iRst),
    .iEn  (coreEn),
    .iClr (coreClr),
    .iDiv (divReg),
    .oTick(coreTick)
  );

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      divReg <= CNT_W'(DEFAULT_DIV);
      budget <= '0;
    end else if (bus.iCfgValid && cfgReady) begin
      divReg <= bus.iCfgDiv;
      budget <= bus.iCfgCount;
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst)          tickCnt <= '0;
    else if (startRun) tickCnt <= '0;
    else if (coreTick) tickCnt <= tickCnt + TICKS_W'(1);
  end

  assign bus.oCfgReady = cfgReady;
  assign bus.oTick     = coreTick;
  assign bus.oBusy     = (state == RUN);
  assign bus.oDone     = (state == DONE);
  assign bus.oTickCnt  = tickCnt;
  assign bus.dbgState  = state;

endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl: directed scenarios plus random control traffic compared
// cycle by cycle against a behavioural model of the divider.
module tb_div_ctrl;
  import div_pkg::*;

  localparam int CNT_W   = 26;
  localparam int TICKS_W = 16;
  localparam int DEF_D   = 7;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DONE  = 2;

  logic iClk = 1'b0;
  logic iRst;

  div_ctrl_if #(.CNT_W(CNT_W), .TICKS_W(TICKS_W)) bus ();

  div_ctrl #(.CNT_W(CNT_W), .TICKS_W(TICKS_W), .DEFAULT_DIV(DEF_D)) dut (
    .iClk(iClk),
    .iRst(iRst),
    .bus (bus)
  );

  // clock / reset
  always #5 iClk = ~iClk;

  // scoreboard and reference model
  int                 checks   = 0;
  int                 failures = 0;
  logic [TICKS_W-1:0] exp_q[$];
  int                 mMode;
  longint             mElapsed;
  longint             mDiv;
  logic [TICKS_W-1:0] mBudget;
  logic [TICKS_W-1:0] mTickCnt;
  bit                 expTickNow;
  bit                 dutTickPrev;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic model_reset();
    mMode       = M_IDLE;
    mElapsed    = 0;
    mDiv        = DEF_D;
    mBudget     = '0;
    mTickCnt    = '0;
    dutTickPrev = 1'b0;
    exp_q.delete();
  endtask

  // Compare every output of the current cycle with the model.
  task automatic sample_check();
    expTickNow = (mMode == M_RUN) && (((mElapsed + 1) % (mDiv + 1)) == 0);
    if (dutTickPrev) begin
      if (exp_q.size() == 0) check("tick_q_empty", 32'd1, 32'd0);
      else                   check("tick_cnt_after_tick", 32'(bus.oTickCnt), 32'(exp_q.pop_front()));
    end
    check("tick",  32'(bus.oTick),     32'(expTickNow));
    check("busy",  32'(bus.oBusy),     32'(mMode == M_RUN));
    check("done",  32'(bus.oDone),     32'(mMode == M_DONE));
    check("ready", 32'(bus.oCfgReady), 32'(mMode != M_RUN));
    check("tcnt",  32'(bus.oTickCnt),  32'(mTickCnt));
    check("state", 32'(bus.dbgState),  32'(mMode));
    dutTickPrev = bus.oTick;
  endtask

  // Apply the current inputs to the model, then move to the next cycle.
  task automatic advance();
    if (bus.iCfgValid && (mMode != M_RUN)) begin
      mDiv    = longint'(bus.iCfgDiv);
      mBudget = bus.iCfgCount;
    end
    if (mMode == M_RUN) begin
      if (expTickNow) begin
        mTickCnt = mTickCnt + 1'b1;
        exp_q.push_back(mTickCnt);
      end
      if (bus.iStop)                                              mMode = M_IDLE;
      else if (expTickNow && mBudget != 0 && mTickCnt == mBudget) mMode = M_DONE;
      else                                                        mElapsed++;
    end else begin
      if (bus.iStop) mMode = M_IDLE;
      else if (bus.iStart) begin
        mMode    = M_RUN;
        mElapsed = 0;
        mTickCnt = '0;
      end
    end
    @(posedge iClk);
    @(negedge iClk);
  endtask

  // driver tasks
  task automatic idle_inputs();
    bus.iCfgValid = 1'b0;
    bus.iCfgDiv   = '0;
    bus.iCfgCount = '0;
    bus.iStart    = 1'b0;
    bus.iStop     = 1'b0;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      sample_check();
      advance();
    end
  endtask

  task automatic do_cfg(input int d, input int c);
    bus.iCfgValid = 1'b1;
    bus.iCfgDiv   = CNT_W'(d);
    bus.iCfgCount = TICKS_W'(c);
    run_cycles(1);
    bus.iCfgValid = 1'b0;
  endtask

  task automatic pulse_start();
    bus.iStart = 1'b1;
    run_cycles(1);
    bus.iStart = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.iStop = 1'b1;
    run_cycles(1);
    bus.iStop = 1'b0;
  endtask

  initial begin
    iRst = 1'b1;
    idle_inputs();
    model_reset();
    @(negedge iClk);
    @(negedge iClk);
    iRst = 1'b0;
    run_cycles(2);

    // default divide value after reset
    pulse_start();
    run_cycles(20);
    pulse_stop();

    // continuous, div=3
    do_cfg(3, 0);
    pulse_start();
    run_cycles(16);
    pulse_stop();
    run_cycles(2);

    // one-shot div=1, budget 3, then restart from DONE
    do_cfg(1, 3);
    pulse_start();
    run_cycles(12);
    pulse_start();
    run_cycles(3);
    pulse_stop();

    // config held off during RUN, accepted in the first IDLE cycle
    do_cfg(4, 0);
    pulse_start();
    bus.iCfgValid = 1'b1;
    bus.iCfgDiv   = CNT_W'(2);
    bus.iCfgCount = TICKS_W'(0);
    run_cycles(8);
    bus.iStop = 1'b1;
    run_cycles(1);
    bus.iStop = 1'b0;
    run_cycles(1);
    bus.iCfgValid = 1'b0;
    pulse_start();
    run_cycles(10);

    // stop landing exactly on a tick cycle
    for (int i = 0; i < 20; i++) begin
      sample_check();
      bus.iStop = expTickNow && (i > 5);
      advance();
      if (bus.iStop) break;
    end
    bus.iStop = 1'b0;
    run_cycles(2);

    // start and stop together in IDLE: stop wins
    bus.iStart = 1'b1;
    bus.iStop  = 1'b1;
    run_cycles(2);
    idle_inputs();
    run_cycles(1);

    // asynchronous reset mid-run, no clock edge involved
    do_cfg(5, 0);
    pulse_start();
    run_cycles(9);
    #2 iRst = 1'b1;
    #1;
    check("rst_busy",  32'(bus.oBusy),     32'd0);
    check("rst_done",  32'(bus.oDone),     32'd0);
    check("rst_tick",  32'(bus.oTick),     32'd0);
    check("rst_ready", 32'(bus.oCfgReady), 32'd1);
    check("rst_tcnt",  32'(bus.oTickCnt),  32'd0);
    model_reset();
    #1 iRst = 1'b0;
    idle_inputs();
    advance();
    pulse_start();
    run_cycles(18);
    pulse_stop();

    // random control and config traffic
    for (int i = 0; i < 500; i++) begin
      sample_check();
      bus.iStart    = ($urandom_range(0, 3) == 0);
      bus.iStop     = ($urandom_range(0, 19) == 0);
      bus.iCfgValid = ($urandom_range(0, 3) == 0);
      bus.iCfgDiv   = CNT_W'($urandom_range(0, 4));
      bus.iCfgCount = TICKS_W'($urandom_range(0, 4));
      advance();
    end
    idle_inputs();
    pulse_stop();

    // div=0 continuous: tick every cycle, counter wraps without DONE
    do_cfg(0, 0);
    pulse_start();
    run_cycles(70000);
    pulse_stop();
    run_cycles(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
